// File: rtl/imem_uart_loader.sv
// UART boot loader: receives A5 / CNT_LO / CNT_HI / CNT little-endian words and writes them
// into instruction memory while holding the core in reset. Optional LOADER_CHECKSUM_EN adds an XOR checksum byte.
module imem_uart_loader #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int BAUD           = 115200,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_resetn,
    output logic                  loading,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    localparam int          DIV   = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int          BCW   = $clog2(DIV + 1);
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);
    localparam logic [7:0]  HDR   = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE, S_ERROR
    } state_t;

    rx_state_t       r_rx_state;
    logic [2:0]      r_rx_sync;
    logic [BCW-1:0]  r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_rx_shift;
    logic            r_byte_valid;
    logic            r_frame_err;

    // NOTE: the synchroniser resets to 1 (line idle) so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_sync    <= '1;
            r_rx_state   <= RX_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_sync    <= {r_rx_sync[1:0], uart_rx};
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_baud_cnt <= '0;
                    if (r_rx_sync[2] && !r_rx_sync[1]) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_baud_cnt == BCW'(DIV / 2 - 1)) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_baud_cnt == BCW'(DIV - 1)) begin
                        r_baud_cnt <= '0;
                        r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_baud_cnt == BCW'(DIV - 1)) begin
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync[1];
                        r_frame_err  <= !r_rx_sync[1];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    state_t                r_state;
    logic [15:0]           r_cnt;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_word;
    logic [TW-1:0]         r_timer;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic                  r_core_resetn;
    logic                  r_loading;
    logic                  r_load_error;
    logic [15:0]           r_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic        w_active;
    logic        w_timeout;
    logic        w_last;
    logic [15:0] w_cnt_full;

    always_comb begin
        w_active = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
        if (r_state == S_CHECK) w_active = 1'b1;
`endif
    end

    assign w_timeout  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_last     = ((r_words + 16'd1) == r_cnt);
    assign w_cnt_full = {r_rx_shift, r_cnt[7:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_byte_idx    <= '0;
            r_word        <= '0;
            r_timer       <= '0;
            r_imem_we     <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_core_resetn <= 1'b0;
            r_loading     <= 1'b0;
            r_load_error  <= 1'b0;
            r_words       <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            // NOTE: the write strobe defaults low here so it can only ever be a single-cycle pulse.
            r_imem_we <= 1'b0;
            r_timer   <= (r_byte_valid || !w_active) ? '0 : r_timer + 1'b1;
            if ((r_frame_err && r_state != S_IDLE) || (w_active && w_timeout && !r_byte_valid)) begin
                r_state       <= S_ERROR;
                r_load_error  <= 1'b1;
                r_loading     <= 1'b0;
                r_core_resetn <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (r_byte_valid && r_rx_shift == HDR) begin
                            r_state       <= S_LEN_LO;
                            r_core_resetn <= 1'b0;
                            r_loading     <= 1'b1;
                            r_load_error  <= 1'b0;
                            r_words       <= '0;
                            r_waddr       <= '0;
                            r_byte_idx    <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum        <= '0;
`endif
                        end else if (r_state == S_IDLE) begin
                            r_core_resetn <= 1'b1;
                        end
                    end
                    S_LEN_LO: begin
                        if (r_byte_valid) begin
                            r_cnt[7:0] <= r_rx_shift;
                            r_state    <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (r_byte_valid) begin
                            r_cnt <= w_cnt_full;
                            if ({1'b0, w_cnt_full} > DEPTH) begin
                                r_state      <= S_ERROR;
                                r_load_error <= 1'b1;
                                r_loading    <= 1'b0;
                            end else if (w_cnt_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state   <= S_CHECK;
`else
                                r_state   <= S_DONE;
                                r_loading <= 1'b0;
`endif
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_imem_we) begin
                            r_words <= r_words + 16'd1;
                            if (r_waddr != '1) r_waddr <= r_waddr + 1'b1;
                            if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state   <= S_CHECK;
`else
                                r_state   <= S_DONE;
                                r_loading <= 1'b0;
`endif
                            end
                        end else if (r_byte_valid) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= r_csum ^ r_rx_shift;
`endif
                            case (r_byte_idx)
                                2'd0:    r_word[7:0]   <= r_rx_shift;
                                2'd1:    r_word[15:8]  <= r_rx_shift;
                                2'd2:    r_word[23:16] <= r_rx_shift;
                                default: begin
                                    r_wdata   <= {r_rx_shift, r_word};
                                    r_imem_we <= 1'b1;
                                end
                            endcase
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (r_byte_valid) begin
                            r_loading <= 1'b0;
                            if (r_rx_shift == r_csum) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state      <= S_ERROR;
                                r_load_error <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        // DONE: loading already dropped on entry, so the core is released one cycle later.
                        r_core_resetn <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_waddr   = r_waddr;
    assign imem_wdata   = r_wdata;
    assign core_resetn  = r_core_resetn;
    assign loading      = r_loading;
    assign load_error   = r_load_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: UART frames driven bit by bit, results compared
// against a frame-parsing reference model. Honours LOADER_CHECKSUM_EN when defined.
module tb_imem_uart_loader;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    logic        we0, core0, load0, err0;
    logic [9:0]  waddr0;
    logic [31:0] wdata0;
    logic [15:0] words0;
    logic        we1, core1, load1, err1;
    logic [3:0]  waddr1;
    logic [31:0] wdata1;
    logic [15:0] words1;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wa0_q[$], wd0_q[$], wa1_q[$], wd1_q[$];
    bit          exp_err;
    int          exp_words;

    imem_uart_loader #(
        .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(1000)
    ) u_dut (
        .clk(clk), .resetn(resetn), .uart_rx(rx0),
        .imem_we(we0), .imem_waddr(waddr0), .imem_wdata(wdata0),
        .core_resetn(core0), .loading(load0), .load_error(err0), .words_loaded(words0)
    );

    imem_uart_loader #(
        .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(1000)
    ) u_small (
        .clk(clk), .resetn(resetn), .uart_rx(rx1),
        .imem_we(we1), .imem_waddr(waddr1), .imem_wdata(wdata1),
        .core_resetn(core1), .loading(load1), .load_error(err1), .words_loaded(words1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we0) begin
            wa0_q.push_back(32'(waddr0));
            wd0_q.push_back(wdata0);
            if (core0) overlap++;
        end
        if (we1) begin
            wa1_q.push_back(32'(waddr1));
            wd1_q.push_back(wdata1);
            if (core1) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: parse the frame in tx_q into the list of words the memory should receive.
    task automatic model_load(input int depth);
        int cnt;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_words = 0;
        cnt = int'({tx_q[2], tx_q[1]});
        if (cnt > depth) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < cnt; w++)
            exp_q.push_back({tx_q[3+4*w+3], tx_q[3+4*w+2], tx_q[3+4*w+1], tx_q[3+4*w]});
        exp_words = cnt;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 3; i < 3 + 4 * cnt; i++) x ^= tx_q[i];
            if (tx_q[3+4*cnt] !== x) exp_err = 1'b1;
        end
`endif
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input bit bad_stop);
        drive(which, 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            repeat (10) @(negedge clk);
        end
        drive(which, !bad_stop);
        repeat (10) @(negedge clk);
        drive(which, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic build_random(input int cnt);
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(cnt[7:0]);
        tx_q.push_back(cnt[15:8]);
        for (int i = 0; i < 4 * cnt; i++) tx_q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 3; i < 3 + 4 * cnt; i++) x ^= tx_q[i];
            tx_q.push_back(x);
        end
`endif
    endtask

    task automatic clear_writes();
        wa0_q.delete(); wd0_q.delete(); wa1_q.delete(); wd1_q.delete();
    endtask

    task automatic compare_writes(input int which, input string tag);
        int n;
        n = (which == 0) ? wa0_q.size() : wa1_q.size();
        check({tag, "_nwrites"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "_waddr"}, (which == 0) ? wa0_q[i] : wa1_q[i], 32'(i));
            check({tag, "_wdata"}, (which == 0) ? wd0_q[i] : wd1_q[i], exp_q[i]);
        end
    endtask

    task automatic run_load(input int which, input string tag);
        model_load((which == 0) ? 1024 : 16);
        clear_writes();
        send_byte(which, tx_q[0], 1'b0);
        check({tag, "_hdr_core"}, 32'((which == 0) ? core0 : core1), 32'(0));
        check({tag, "_hdr_loading"}, 32'((which == 0) ? load0 : load1), 32'(1));
        for (int i = 1; i < tx_q.size(); i++) send_byte(which, tx_q[i], 1'b0);
        repeat (30) @(negedge clk);
        compare_writes(which, tag);
        check({tag, "_words"}, 32'((which == 0) ? words0 : words1), 32'(exp_words));
        check({tag, "_err"}, 32'((which == 0) ? err0 : err1), 32'(exp_err));
        check({tag, "_core"}, 32'((which == 0) ? core0 : core1), 32'(!exp_err));
        check({tag, "_loading"}, 32'((which == 0) ? load0 : load1), 32'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(we0), 32'(0));
        check({tag, "_waddr"}, 32'(waddr0), 32'(0));
        check({tag, "_wdata"}, wdata0, 32'(0));
        check({tag, "_core"}, 32'(core0), 32'(0));
        check({tag, "_loading"}, 32'(load0), 32'(0));
        check({tag, "_err"}, 32'(err0), 32'(0));
        check({tag, "_words"}, 32'(words0), 32'(0));
        check({tag, "_small_core"}, 32'(core1), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("por_release_core", 32'(core0), 32'(1));
        repeat (5) @(negedge clk);

        // Directed two-word load.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
`endif
        run_load(0, "two_words");
        check("two_words_w0", (wd0_q.size() > 0) ? wd0_q[0] : 32'hx, 32'hDEADBEEF);
        check("two_words_w1", (wd0_q.size() > 1) ? wd0_q[1] : 32'hx, 32'h12345678);

        // Empty program.
        tx_q = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(8'h00);
`endif
        run_load(0, "cnt_zero");

        // Framing error on the third data byte, then a clean reload.
        clear_writes();
        send_byte(0, 8'hA5, 1'b0);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b0);
        send_byte(0, 8'h33, 1'b1);
        repeat (30) @(negedge clk);
        check("frame_err", 32'(err0), 32'(1));
        check("frame_core", 32'(core0), 32'(0));
        check("frame_loading", 32'(load0), 32'(0));
        check("frame_nwrites", 32'(wa0_q.size()), 32'(0));
        build_random(3);
        run_load(0, "reload");

        // Inter-byte timeout.
        clear_writes();
        send_byte(0, 8'hA5, 1'b0);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b0);
        repeat (900) @(negedge clk);
        check("tmo_before_loading", 32'(load0), 32'(1));
        check("tmo_before_err", 32'(err0), 32'(0));
        repeat (200) @(negedge clk);
        check("tmo_err", 32'(err0), 32'(1));
        check("tmo_loading", 32'(load0), 32'(0));
        check("tmo_core", 32'(core0), 32'(0));
        check("tmo_nwrites", 32'(wa0_q.size()), 32'(0));

        // Randomised programs.
        for (int k = 0; k < 3; k++) begin
            build_random(int'($urandom_range(1, 5)));
            run_load(0, "rand");
        end

        // Length limit on a 16-word memory: 17 rejected, 16 accepted.
        tx_q = '{8'hA5, 8'h11, 8'h00};
        run_load(1, "small_over");
        build_random(16);
        run_load(1, "small_full");

        // Reset in the middle of the second word.
        clear_writes();
        send_byte(0, 8'hA5, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(0, 8'($urandom), 1'b0);
        repeat (20) @(negedge clk);
        check("midrst_words_before", 32'(words0), 32'(1));
        check("midrst_loading_before", 32'(load0), 32'(1));
        resetn = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_release_core", 32'(core0), 32'(1));
        repeat (50) @(negedge clk);
        check("midrst_nwrites", 32'(wa0_q.size()), 32'(1));
        check("midrst_loading_after", 32'(load0), 32'(0));

`ifdef LOADER_CHECKSUM_EN
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_load(0, "csum_ok");
        check("csum_ok_w0", (wd0_q.size() > 0) ? wd0_q[0] : 32'hx, 32'h08040201);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_load(0, "csum_bad");
        check("csum_bad_err", 32'(err0), 32'(1));
`endif

        check("no_write_while_core_running", 32'(overlap), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
